// File: rtl/huffman_pkg.sv
// Shared constants and FSM encoding for the Huffman coder/decoder pair.
package huffman_pkg;

    localparam int CODE_W   = 10;
    localparam int LEN_W    = 4;
    localparam int SYM_W    = 7;
    localparam int NUM_SYMS = 1 << SYM_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // A code length is usable only if it is non-zero and fits the code field.
    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(CODE_W));
    endfunction

endpackage

// File: rtl/huffman_table.sv
// Static code book: 0x60..0x7F get 6-bit codes 0xxxxx, every other symbol an 8-bit code 1sssssss.
module huffman_table
    import huffman_pkg::*;
(
    input  logic [SYM_W-1:0]  ascii_i,
    output logic [CODE_W-1:0] huffman_code_o,
    output logic [LEN_W-1:0]  bit_length_o
);

    always_comb begin
        huffman_code_o = '0;
        bit_length_o   = '0;
        if (ascii_i[SYM_W-1 -: 2] == 2'b11) begin
            huffman_code_o = CODE_W'(ascii_i[SYM_W-3:0]);
            bit_length_o   = LEN_W'(6);
        end else begin
            huffman_code_o = CODE_W'({1'b1, ascii_i});
            bit_length_o   = LEN_W'(8);
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder: captures one code word per handshake and scans the code table
// one entry per cycle, lowest index first, to recover the symbol.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] huffman_in,
    input  logic [LEN_W-1:0]  bit_length_in,
    input  logic              valid_in,
    output logic              load_out,
    output logic [SYM_W-1:0]  ascii_out,
    output logic              error,
    output logic              valid_out,
    input  logic              ack,
    output state_t            state_o
);

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [SYM_W-1:0]  ascii_q, ascii_d;
    logic              error_q, error_d;
    logic              valid_q, valid_d;
    logic [SYM_W-1:0]  idx_q, idx_d;
    logic              armed_q, armed_d;
    logic              ack_prev_q, ack_prev_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [CODE_W-1:0] tbl_code;
    logic [LEN_W-1:0]  tbl_len;
    logic              match;
    logic              last_idx;
    logic              ack_rise;

    huffman_table u_table (
        .ascii_i        (idx_q),
        .huffman_code_o (tbl_code),
        .bit_length_o   (tbl_len)
    );

    assign match    = (tbl_code == code_q) && (tbl_len == len_q);
    assign last_idx = (idx_q == SYM_W'(NUM_SYMS - 1));
    assign ack_rise = ack && !ack_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            ascii_q    <= '0;
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            armed_q    <= 1'b1;
            ack_prev_q <= 1'b0;
            code_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            ascii_q    <= ascii_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            armed_q    <= armed_d;
            ack_prev_q <= ack_prev_d;
            code_q     <= code_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_d     = 1'b0;
        ascii_d    = ascii_q;
        error_d    = error_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        code_d     = code_q;
        len_d      = len_q;
        ack_prev_d = ack;
        // Re-arm only once the producer has visibly dropped the previous word.
        armed_d    = armed_q | ~valid_in;

        case (state_q)
            IDLE: begin
                if (valid_in && armed_q) begin
                    code_d  = huffman_in;
                    len_d   = bit_length_in;
                    load_d  = 1'b1;
                    armed_d = 1'b0;
                    idx_d   = '0;
                    if (len_ok(bit_length_in)) begin
                        state_d = SEARCH;
                    end else begin
                        state_d = DONE;
                        error_d = 1'b1;
                        ascii_d = '0;
                        valid_d = 1'b1;
                    end
                end
            end
            SEARCH: begin
                if (match) begin
                    ascii_d = idx_q;
                    error_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (last_idx) begin
                    ascii_d = '0;
                    error_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + SYM_W'(1);
                end
            end
            DONE: begin
                if (ack_rise) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_out  = load_q;
        ascii_out = ascii_q;
        error     = error_q;
        valid_out = valid_q;
        state_o   = state_q;
    end

endmodule
